// File: rtl/uart_msg_pkg.sv
// Shared encodings for the UART message generator: command modes,
// terminator selection, terminator characters and FSM states.
package uart_msg_pkg;

    localparam logic [1:0] MODE_INC  = 2'd0;
    localparam logic [1:0] MODE_FILL = 2'd1;
    localparam logic [1:0] MODE_COPY = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    localparam int EOL_NONE = 0;
    localparam int EOL_LF   = 1;
    localparam int EOL_LFCR = 2;

    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_CR = 8'h0D;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BODY = 2'd1,
        S_EOL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Number of terminator characters appended for a given EOL_MODE.
    function automatic int eol_count(input int eol_mode);
        case (eol_mode)
            EOL_LF:   return 1;
            EOL_LFCR: return 2;
            default:  return 0;
        endcase
    endfunction

endpackage

// File: rtl/uart_msg_gen.sv
// Composes a UART TX message into a shared buffer RAM (INC / FILL / COPY body
// plus optional LF/CR terminator), then offers it to the TX side via valid/ready.
module uart_msg_gen
    import uart_msg_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               LEN        = 256,
    parameter logic [WIDTH-1:0] START_CHAR = 8'h41,
    parameter int               EOL_MODE   = 2,
    parameter int               MSG_START  = 0,
    parameter int               BOOT_LEN   = 5,
    localparam int              AW         = $clog2(LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [AW:0]      cmd_len,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [AW-1:0]    wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             wr_en,
    output logic [AW-1:0]    rd_addr,
    output logic             rd_en,
    input  logic [WIDTH-1:0] rd_data,
    output logic             msg_valid,
    input  logic             msg_ready,
    output logic [AW:0]      msg_len,
    output logic             cmd_err
);

    localparam int EOL_N = eol_count(EOL_MODE);

    state_t           state_r;
    logic [1:0]       mode_r;
    logic [AW:0]      len_r;
    logic [WIDTH-1:0] data_r;
    logic [AW:0]      rcnt_r;
    logic [WIDTH-1:0] wr_data_r;
    logic             copy_sel_r;
    logic             boot_r;

    logic             cmd_take_s;
    logic             cmd_bad_s;
    logic             start_s;
    logic [AW+1:0]    need_s;
    logic [1:0]       st_mode_s;
    logic [AW:0]      st_len_s;
    logic [WIDTH-1:0] st_data_s;
    logic             last_body_s;

    // COPY writes take the RAM read data straight through, aligned by copy_sel_r.
    assign wr_data = copy_sel_r ? rd_data : wr_data_r;

    // Command acceptance, length check and boot-message substitution.
    always_comb begin
        cmd_take_s  = cmd_valid && cmd_ready;
        need_s      = {1'b0, cmd_len} + (AW+2)'(EOL_N);
        cmd_bad_s   = (cmd_mode == MODE_RSVD) || (need_s > (AW+2)'(LEN));
        start_s     = boot_r || (cmd_take_s && !cmd_bad_s);
        st_mode_s   = cmd_mode;
        st_len_s    = cmd_len;
        st_data_s   = cmd_data;
        if (boot_r) begin
            st_mode_s = MODE_INC;
            st_len_s  = (AW+1)'(BOOT_LEN);
            st_data_s = '0;
        end else begin
            st_mode_s = cmd_mode;
        end
        last_body_s = wr_en && ({1'b0, wr_addr} == (len_r - (AW+1)'(1)));
    end

    // Message FSM with all buffer-side and handshake outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            mode_r     <= MODE_INC;
            len_r      <= '0;
            data_r     <= '0;
            rcnt_r     <= '0;
            wr_data_r  <= '0;
            copy_sel_r <= 1'b0;
            boot_r     <= (MSG_START != 0);
            cmd_ready  <= (MSG_START == 0);
            wr_addr    <= '0;
            wr_en      <= 1'b0;
            rd_addr    <= '0;
            rd_en      <= 1'b0;
            msg_valid  <= 1'b0;
            msg_len    <= '0;
            cmd_err    <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            cmd_err    <= 1'b0;
            copy_sel_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start_s) begin
                        boot_r    <= 1'b0;
                        cmd_ready <= 1'b0;
                        mode_r    <= st_mode_s;
                        len_r     <= st_len_s;
                        data_r    <= st_data_s;
                        if (st_len_s == '0) begin
                            if (EOL_N == 0) begin
                                state_r   <= S_DONE;
                                msg_valid <= 1'b1;
                                msg_len   <= '0;
                            end else begin
                                state_r   <= S_EOL;
                                wr_en     <= 1'b1;
                                wr_addr   <= '0;
                                wr_data_r <= WIDTH'(CHAR_LF);
                            end
                        end else if (st_mode_s == MODE_COPY) begin
                            state_r <= S_BODY;
                            rd_en   <= 1'b1;
                            rd_addr <= AW'(st_data_s);
                            rcnt_r  <= (AW+1)'(1);
                        end else begin
                            state_r   <= S_BODY;
                            wr_en     <= 1'b1;
                            wr_addr   <= '0;
                            wr_data_r <= (st_mode_s == MODE_INC) ? START_CHAR : st_data_s;
                        end
                    end else if (cmd_take_s) begin
                        cmd_err <= 1'b1;
                    end else begin
                        cmd_err <= 1'b0;
                    end
                end
                S_BODY: begin
                    if (last_body_s) begin
                        if (EOL_N == 0) begin
                            state_r   <= S_DONE;
                            msg_valid <= 1'b1;
                            msg_len   <= len_r;
                        end else begin
                            state_r   <= S_EOL;
                            wr_en     <= 1'b1;
                            wr_addr   <= AW'(len_r);
                            wr_data_r <= WIDTH'(CHAR_LF);
                        end
                    end else if (mode_r == MODE_COPY) begin
                        if (rcnt_r < len_r) begin
                            rd_en   <= 1'b1;
                            rd_addr <= AW'(data_r) + AW'(rcnt_r);
                            rcnt_r  <= rcnt_r + (AW+1)'(1);
                        end else begin
                            rd_en <= 1'b0;
                        end
                        // A read issued last cycle lands in the buffer this cycle.
                        if (rd_en) begin
                            wr_en      <= 1'b1;
                            wr_addr    <= wr_en ? (wr_addr + AW'(1)) : '0;
                            copy_sel_r <= 1'b1;
                        end else begin
                            wr_en <= 1'b0;
                        end
                    end else begin
                        wr_en     <= 1'b1;
                        wr_addr   <= wr_addr + AW'(1);
                        wr_data_r <= (mode_r == MODE_INC)
                                     ? (START_CHAR + WIDTH'(wr_addr) + WIDTH'(1)) : data_r;
                    end
                end
                S_EOL: begin
                    if ((EOL_N == 2) && (wr_data_r == WIDTH'(CHAR_LF))) begin
                        wr_en     <= 1'b1;
                        wr_addr   <= wr_addr + AW'(1);
                        wr_data_r <= WIDTH'(CHAR_CR);
                    end else begin
                        state_r   <= S_DONE;
                        msg_valid <= 1'b1;
                        msg_len   <= len_r + (AW+1)'(EOL_N);
                    end
                end
                S_DONE: begin
                    if (msg_ready) begin
                        state_r   <= S_IDLE;
                        msg_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end else begin
                        msg_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_msg_gen.sv
// Directed bench for uart_msg_gen: three instances (LF+CR default, no terminator,
// boot message) with a write/read monitor and hand-computed expectations.
module tb_uart_msg_gen;
    import uart_msg_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [1:0] cmd_mode = 2'd0;
    logic [8:0] cmd_len = 9'd0;
    logic [7:0] cmd_data = 8'd0;
    logic [7:0] zero_byte = 8'd0;

    logic       cmd_valid_a = 1'b0, cmd_valid_b = 1'b0, cmd_valid_c = 1'b0;
    logic       msg_ready_a = 1'b0, msg_ready_b = 1'b0, msg_ready_c = 1'b0;
    logic       cmd_ready_a, cmd_ready_b, cmd_ready_c;
    logic [7:0] wr_addr_a, wr_addr_b, wr_addr_c;
    logic [7:0] wr_data_a, wr_data_b, wr_data_c;
    logic       wr_en_a, wr_en_b, wr_en_c;
    logic [7:0] rd_addr_a, rd_addr_b, rd_addr_c;
    logic       rd_en_a, rd_en_b, rd_en_c;
    logic [7:0] rd_data_a = 8'd0;
    logic       msg_valid_a, msg_valid_b, msg_valid_c;
    logic [8:0] msg_len_a, msg_len_b, msg_len_c;
    logic       cmd_err_a, cmd_err_b, cmd_err_c;

    uart_msg_gen #(.WIDTH(8), .LEN(256), .START_CHAR(8'h41), .EOL_MODE(2), .MSG_START(0), .BOOT_LEN(5)) dut_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_mode(cmd_mode),
        .cmd_len(cmd_len), .cmd_data(cmd_data), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_en(wr_en_a),
        .rd_addr(rd_addr_a), .rd_en(rd_en_a), .rd_data(rd_data_a), .msg_valid(msg_valid_a),
        .msg_ready(msg_ready_a), .msg_len(msg_len_a), .cmd_err(cmd_err_a));

    uart_msg_gen #(.WIDTH(8), .LEN(256), .START_CHAR(8'h41), .EOL_MODE(0), .MSG_START(0), .BOOT_LEN(5)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_mode(cmd_mode),
        .cmd_len(cmd_len), .cmd_data(cmd_data), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_en(wr_en_b),
        .rd_addr(rd_addr_b), .rd_en(rd_en_b), .rd_data(zero_byte), .msg_valid(msg_valid_b),
        .msg_ready(msg_ready_b), .msg_len(msg_len_b), .cmd_err(cmd_err_b));

    uart_msg_gen #(.WIDTH(8), .LEN(256), .START_CHAR(8'h41), .EOL_MODE(2), .MSG_START(1), .BOOT_LEN(5)) dut_c (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_c), .cmd_ready(cmd_ready_c), .cmd_mode(cmd_mode),
        .cmd_len(cmd_len), .cmd_data(cmd_data), .wr_addr(wr_addr_c), .wr_data(wr_data_c), .wr_en(wr_en_c),
        .rd_addr(rd_addr_c), .rd_en(rd_en_c), .rd_data(zero_byte), .msg_valid(msg_valid_c),
        .msg_ready(msg_ready_c), .msg_len(msg_len_c), .cmd_err(cmd_err_c));

    // Source RAM for COPY: 0x31..0x34 at 0x10..0x13, filler elsewhere.
    always @(posedge clk) begin
        if (rd_en_a) begin
            if (rd_addr_a >= 8'h10 && rd_addr_a <= 8'h13) rd_data_a <= 8'h31 + (rd_addr_a - 8'h10);
            else rd_data_a <= 8'hEE;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wa_addr[$], wa_data[$], wa_cyc[$], ra_addr[$], ra_cyc[$];
    int wb_addr[$], wb_data[$], wb_cyc[$], wc_addr[$], wc_data[$], wc_cyc[$];
    int err_a = 0;

    // Buffer-port monitor; cycle k is the period after the k-th rising edge.
    always @(negedge clk) begin
        if (wr_en_a) begin wa_addr.push_back(int'(wr_addr_a)); wa_data.push_back(int'(wr_data_a)); wa_cyc.push_back(cyc); end
        if (rd_en_a) begin ra_addr.push_back(int'(rd_addr_a)); ra_cyc.push_back(cyc); end
        if (wr_en_b) begin wb_addr.push_back(int'(wr_addr_b)); wb_data.push_back(int'(wr_data_b)); wb_cyc.push_back(cyc); end
        if (wr_en_c) begin wc_addr.push_back(int'(wr_addr_c)); wc_data.push_back(int'(wr_data_c)); wc_cyc.push_back(cyc); end
        if (cmd_err_a) err_a = err_a + 1;
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic vld(input int d);
        case (d)
            0: return msg_valid_a;
            1: return msg_valid_b;
            default: return msg_valid_c;
        endcase
    endfunction

    task automatic send(input int d, input logic [1:0] m, input logic [8:0] l, input logic [7:0] dat, output int acc);
        cmd_mode = m; cmd_len = l; cmd_data = dat;
        if (d == 0) begin check_eq("ready_a_before_cmd", cmd_ready_a, 1); cmd_valid_a = 1'b1; end
        else begin check_eq("ready_b_before_cmd", cmd_ready_b, 1); cmd_valid_b = 1'b1; end
        acc = cyc;
        tick();
        cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
    endtask

    task automatic wait_valid(input int d, output int vc);
        int n = 0;
        while (!vld(d) && n < 200) begin tick(); n++; end
        check_eq("msg_valid_seen", vld(d), 1);
        vc = cyc;
    endtask

    logic [7:0] exp_inc [7] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h0A, 8'h0D};
    logic [7:0] exp_cpy [6] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0A, 8'h0D};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, vc, r;
        rst = 1'b1;
        repeat (3) tick();
        check_eq("rst_cmd_ready_a", cmd_ready_a, 1);
        check_eq("rst_cmd_ready_c", cmd_ready_c, 0);
        check_eq("rst_wr_en_a", wr_en_a, 0);
        check_eq("rst_rd_en_a", rd_en_a, 0);
        check_eq("rst_msg_valid_a", msg_valid_a, 0);
        check_eq("rst_cmd_err_a", cmd_err_a, 0);
        check_eq("rst_msg_len_a", msg_len_a, 0);
        check_eq("rst_wr_addr_a", wr_addr_a, 0);
        rst = 1'b0;
        tick();

        // 1: INC length 5 with LF+CR, then TX backpressure
        wa_addr.delete(); wa_data.delete(); wa_cyc.delete();
        send(0, MODE_INC, 9'd5, 8'd0, k);
        wait_valid(0, vc);
        check_eq("t1_valid_latency", vc, k + 8);
        check_eq("t1_msg_len", msg_len_a, 7);
        check_eq("t1_nwrites", wa_data.size(), 7);
        for (int i = 0; i < 7 && i < wa_data.size(); i++) begin
            check_eq("t1_addr", wa_addr[i], i);
            check_eq("t1_data", wa_data[i], exp_inc[i]);
            check_eq("t1_cycle", wa_cyc[i], k + 1 + i);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t1_valid_held", msg_valid_a, 1);
        end
        check_eq("t1_ready_low_in_done", cmd_ready_a, 0);
        msg_ready_a = 1'b1;
        tick();
        msg_ready_a = 1'b0;
        check_eq("t1_valid_drop", msg_valid_a, 0);
        check_eq("t1_ready_back", cmd_ready_a, 1);

        // 2: FILL 0x2A length 3, no terminator
        send(1, MODE_FILL, 9'd3, 8'h2A, k);
        wait_valid(1, vc);
        check_eq("t2_valid_latency", vc, k + 4);
        check_eq("t2_msg_len", msg_len_b, 3);
        check_eq("t2_nwrites", wb_data.size(), 3);
        for (int i = 0; i < 3 && i < wb_data.size(); i++) begin
            check_eq("t2_addr", wb_addr[i], i);
            check_eq("t2_data", wb_data[i], 8'h2A);
            check_eq("t2_cycle", wb_cyc[i], k + 1 + i);
        end
        msg_ready_b = 1'b1; tick(); msg_ready_b = 1'b0;
        check_eq("t2_ready_back", cmd_ready_b, 1);

        // 3: COPY 4 entries from 0x10
        wa_addr.delete(); wa_data.delete(); wa_cyc.delete();
        send(0, MODE_COPY, 9'd4, 8'h10, k);
        wait_valid(0, vc);
        check_eq("t3_valid_latency", vc, k + 8);
        check_eq("t3_msg_len", msg_len_a, 6);
        check_eq("t3_nreads", ra_addr.size(), 4);
        for (int i = 0; i < 4 && i < ra_addr.size(); i++) begin
            check_eq("t3_rd_addr", ra_addr[i], 8'h10 + i);
            check_eq("t3_rd_cycle", ra_cyc[i], k + 1 + i);
        end
        check_eq("t3_nwrites", wa_data.size(), 6);
        for (int i = 0; i < 6 && i < wa_data.size(); i++) begin
            check_eq("t3_addr", wa_addr[i], i);
            check_eq("t3_data", wa_data[i], exp_cpy[i]);
            check_eq("t3_cycle", wa_cyc[i], k + 2 + i);
        end
        msg_ready_a = 1'b1; tick(); msg_ready_a = 1'b0;

        // 4: rejected commands, then an empty body
        wa_addr.delete(); wa_data.delete(); wa_cyc.delete();
        err_a = 0;
        send(0, MODE_RSVD, 9'd2, 8'd0, k);
        repeat (4) tick();
        check_eq("t4_mode3_err", err_a, 1);
        check_eq("t4_mode3_nwrites", wa_data.size(), 0);
        check_eq("t4_mode3_ready", cmd_ready_a, 1);
        err_a = 0;
        send(0, MODE_INC, 9'd255, 8'd0, k);
        repeat (4) tick();
        check_eq("t4_len_err", err_a, 1);
        check_eq("t4_len_nwrites", wa_data.size(), 0);
        send(0, MODE_INC, 9'd0, 8'd0, k);
        wait_valid(0, vc);
        check_eq("t4_zero_latency", vc, k + 3);
        check_eq("t4_zero_msg_len", msg_len_a, 2);
        check_eq("t4_zero_nwrites", wa_data.size(), 2);
        if (wa_data.size() == 2) begin
            check_eq("t4_zero_lf", wa_data[0], 8'h0A);
            check_eq("t4_zero_cr", wa_data[1], 8'h0D);
            check_eq("t4_zero_cr_addr", wa_addr[1], 1);
        end
        msg_ready_a = 1'b1; tick(); msg_ready_a = 1'b0;

        // 5: reset during BODY, then boot message on the MSG_START instance
        wa_addr.delete(); wa_data.delete(); wa_cyc.delete();
        send(0, MODE_INC, 9'd5, 8'd0, k);
        tick(); tick();
        check_eq("t5_mid_wr_addr", wr_addr_a, 2);
        rst = 1'b1;
        tick();
        check_eq("t5_rst_wr_en", wr_en_a, 0);
        check_eq("t5_rst_ready", cmd_ready_a, 1);
        check_eq("t5_rst_valid", msg_valid_a, 0);
        check_eq("t5_rst_valid_c", msg_valid_c, 0);
        check_eq("t5_rst_ready_c", cmd_ready_c, 0);
        wc_addr.delete(); wc_data.delete(); wc_cyc.delete();
        rst = 1'b0;
        r = cyc;
        wait_valid(2, vc);
        check_eq("t5_boot_latency", vc, r + 8);
        check_eq("t5_boot_msg_len", msg_len_c, 7);
        check_eq("t5_boot_nwrites", wc_data.size(), 7);
        for (int i = 0; i < 7 && i < wc_data.size(); i++) begin
            check_eq("t5_boot_addr", wc_addr[i], i);
            check_eq("t5_boot_data", wc_data[i], exp_inc[i]);
            check_eq("t5_boot_cycle", wc_cyc[i], r + 1 + i);
        end
        check_eq("t5_aborted_nwrites", wa_data.size(), 3);
        check_eq("t5_a_idle_valid", msg_valid_a, 0);
        msg_ready_c = 1'b1; tick(); msg_ready_c = 1'b0;
        check_eq("t5_boot_ready_back", cmd_ready_c, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
